// File: rtl/riscv.sv
// Core-wide architectural constants.
// Shared by the RVFI record types and the commit sequencer.
package riscv;
    localparam int unsigned XLEN = 64;
endpackage

// File: rtl/rvfi_pkg.sv
// RVFI retirement record as seen on each commit port.
// Packed so it can be stored and replayed as a single word.
package rvfi_pkg;
    import riscv::*;

    typedef struct packed {
        logic              valid;
        logic              trap;
        logic              halt;
        logic              intr;
        logic [63:0]       order;
        logic [31:0]       insn;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   mem_addr;
        logic [XLEN/8-1:0] mem_wmask;
        logic [XLEN-1:0]   mem_wdata;
    } rvfi_instr_t;
endpackage

// File: rtl/rvfi_commit_sequencer.sv
// In-order single-stream replay of a multi-port RVFI commit bus.
// Optional tohost exit detection is enabled by RVFI_SEQ_TOHOST_EN.
module rvfi_commit_sequencer
    import rvfi_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 8,
    parameter logic [7:0]  HART_ID         = 8'd0
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  rvfi_instr_t [NR_COMMIT_PORTS-1:0]   rvfi_i,
    input  logic                                flush_i,
    output rvfi_instr_t                         rvfi_o,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [$clog2(DEPTH):0]              level_o,
    output logic                                overflow_o,
    output logic [31:0]                         drop_cnt_o
`ifdef RVFI_SEQ_TOHOST_EN
    ,
    input  logic [riscv::XLEN-1:0]              tohost_addr_i,
    output logic                                exit_valid_o,
    output logic [riscv::XLEN-1:0]              exit_code_o
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned CW = $clog2(NR_COMMIT_PORTS + 1);

    rvfi_instr_t mem_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [LW-1:0] level_q;
    logic          overflow_q;
    logic [31:0]   drop_q;

    logic                       pop;
    logic [LW-1:0]              base_lvl;
    logic [PW-1:0]              wr_base;
    logic [LW-1:0]              free;
    logic [LW-1:0]              n_acc;
    logic [CW-1:0]              n_drop;
    logic [NR_COMMIT_PORTS-1:0] we;
    logic [PW-1:0]              widx [NR_COMMIT_PORTS];
    logic [32:0]                drop_sum;

    assign valid_o    = (level_q != '0);
    assign rvfi_o     = valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_q;

    // Flush empties the queue first, so this cycle's captures land at slot 0.
    always_comb begin
        pop      = valid_o & ready_i & ~flush_i;
        base_lvl = flush_i ? '0 : level_q;
        wr_base  = flush_i ? '0 : wr_ptr_q;
        free     = LW'(DEPTH) - base_lvl + LW'(pop);
        n_acc    = '0;
        n_drop   = '0;
        we       = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            widx[k] = '0;
            if (rvfi_i[k].valid | rvfi_i[k].trap) begin
                if (n_acc < free) begin
                    we[k]   = 1'b1;
                    widx[k] = wr_base + PW'(n_acc);
                    n_acc   = n_acc + LW'(1);
                end else begin
                    n_drop = n_drop + CW'(1);
                end
            end
        end
        drop_sum = {1'b0, drop_q} + 33'(n_drop);
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            if (we[k]) mem_q[widx[k]] <= rvfi_i[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            rd_ptr_q <= flush_i ? '0 : rd_ptr_q + PW'(pop);
            wr_ptr_q <= wr_base + PW'(n_acc);
            level_q  <= base_lvl + n_acc - LW'(pop);
            if (n_drop != '0) begin
                overflow_q <= 1'b1;
                drop_q     <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
            end
        end
    end

`ifdef RVFI_SEQ_TOHOST_EN
    logic                   hit;
    logic [riscv::XLEN-1:0] hit_data;
    logic                   exit_valid_q;
    logic [riscv::XLEN-1:0] exit_code_q;

    // Only accepted records qualify; ascending scan gives lowest port priority.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            if (!hit && we[k] && tohost_addr_i != '0
                && rvfi_i[k].mem_addr == tohost_addr_i
                && rvfi_i[k].mem_wmask != '0
                && rvfi_i[k].mem_wdata[0]) begin
                hit      = 1'b1;
                hit_data = rvfi_i[k].mem_wdata;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exit_valid_q <= 1'b0;
            exit_code_q  <= '0;
        end else if (!exit_valid_q && hit) begin
            exit_valid_q <= 1'b1;
            exit_code_q  <= hit_data;
        end
    end

    assign exit_valid_o = exit_valid_q;
    assign exit_code_o  = exit_code_q;
`endif

    level_bound: assert property (
        @(posedge clk_i) disable iff (!rst_ni) level_q <= LW'(DEPTH)
    ) else $error("rvfi_seq hart %0d: level exceeds depth", HART_ID);

endmodule

// File: tb/tb_rvfi_commit_sequencer.sv
// Randomized bench for rvfi_commit_sequencer against a queue-based model.
// Directed scenarios pin the model with literal expectations.
module tb_rvfi_commit_sequencer;
    import rvfi_pkg::*;

    localparam int NR    = 2;
    localparam int DEPTH = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    rvfi_instr_t [NR-1:0] rvfi;
    logic                 flush = 1'b0;
    rvfi_instr_t          dut_rvfi;
    logic                 dut_valid;
    logic                 ready = 1'b0;
    logic [3:0]           dut_level;
    logic                 dut_ovf;
    logic [31:0]          dut_drop;
`ifdef RVFI_SEQ_TOHOST_EN
    logic [63:0]          tohost = 64'h0;
    logic                 dut_exit_v;
    logic [63:0]          dut_exit_c;
`endif

    always #5 clk = ~clk;

    rvfi_commit_sequencer #(
        .NR_COMMIT_PORTS(NR),
        .DEPTH(DEPTH),
        .HART_ID(8'd0)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .rvfi_i(rvfi),
        .flush_i(flush),
        .rvfi_o(dut_rvfi),
        .valid_o(dut_valid),
        .ready_i(ready),
        .level_o(dut_level),
        .overflow_o(dut_ovf),
        .drop_cnt_o(dut_drop)
`ifdef RVFI_SEQ_TOHOST_EN
        ,
        .tohost_addr_i(tohost),
        .exit_valid_o(dut_exit_v),
        .exit_code_o(dut_exit_c)
`endif
    );

    rvfi_instr_t mq[$];
    bit          m_ovf;
    logic [31:0] m_drop;
    bit          m_exit;
    logic [63:0] m_code;
    int          checks = 0;
    int          failures = 0;
    bit          chk_en = 1'b0;

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", n, act, exp);
        end
    endtask

    function automatic rvfi_instr_t mk(logic v, logic t, logic [63:0] pc);
        rvfi_instr_t r;
        r = '0;
        r.valid     = v;
        r.trap      = t;
        r.pc        = pc;
        r.order     = {$urandom(), $urandom()};
        r.insn      = $urandom();
        r.mem_wdata = {$urandom(), $urandom()};
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = '0;
        m_exit = 1'b0;
        m_code = '0;
    endtask

    // Queue semantics straight from the behaviour rules.
    task automatic model_step();
        int  room;
        bit  pop;
        pop = (mq.size() != 0) && ready && !flush;
        if (flush) mq.delete();
        else if (pop) void'(mq.pop_front());
        room = DEPTH - mq.size();
        for (int k = 0; k < NR; k++) begin
            if (rvfi[k].valid || rvfi[k].trap) begin
                if (room > 0) begin
                    mq.push_back(rvfi[k]);
                    room--;
`ifdef RVFI_SEQ_TOHOST_EN
                    if (!m_exit && tohost != 0 && rvfi[k].mem_addr == tohost
                        && rvfi[k].mem_wmask != 0 && rvfi[k].mem_wdata[0]) begin
                        m_exit = 1'b1;
                        m_code = rvfi[k].mem_wdata;
                    end
`endif
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 32'hFFFF_FFFF) m_drop++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
    endtask

    task automatic idle_in();
        rvfi[0] = '0;
        rvfi[1] = '0;
        flush   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            rvfi_instr_t e;
            e = (mq.size() != 0) ? mq[0] : '0;
            chk("valid_o", 64'(dut_valid), 64'(mq.size() != 0));
            chk("level_o", 64'(dut_level), 64'(mq.size()));
            chk("overflow_o", 64'(dut_ovf), 64'(m_ovf));
            chk("drop_cnt_o", 64'(dut_drop), 64'(m_drop));
            checks++;
            if (dut_rvfi !== e) begin
                failures++;
                $display("FAIL rvfi_o act_pc=%h exp_pc=%h act_order=%h exp_order=%h",
                         dut_rvfi.pc, e.pc, dut_rvfi.order, e.order);
            end
`ifdef RVFI_SEQ_TOHOST_EN
            chk("exit_valid_o", 64'(dut_exit_v), 64'(m_exit));
            chk("exit_code_o", dut_exit_c, m_code);
`endif
        end
    end

    initial begin
        idle_in();
        model_reset();
        #12;
        chk("rst valid", 64'(dut_valid), 64'd0);
        chk("rst level", 64'(dut_level), 64'd0);
        chk("rst ovf", 64'(dut_ovf), 64'd0);
        chk("rst drop", 64'(dut_drop), 64'd0);
        chk("rst rvfi_o", dut_rvfi.pc, 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // In-order replay
        ready   = 1'b1;
        rvfi[0] = mk(1, 0, 64'hA000);
        rvfi[1] = mk(1, 0, 64'hB000);
        tick();
        idle_in();
        chk("replay pc0", dut_rvfi.pc, 64'hA000);
        chk("replay lvl2", 64'(dut_level), 64'd2);
        tick();
        chk("replay pc1", dut_rvfi.pc, 64'hB000);
        chk("replay lvl1", 64'(dut_level), 64'd1);
        tick();
        chk("replay lvl0", 64'(dut_level), 64'd0);

        // Sparse capture
        ready   = 1'b0;
        rvfi[1] = mk(0, 1, 64'hC000);
        tick();
        idle_in();
        chk("sparse lvl", 64'(dut_level), 64'd1);
        chk("sparse pc", dut_rvfi.pc, 64'hC000);
        chk("sparse trap", 64'(dut_rvfi.trap), 64'd1);
        ready = 1'b1;
        tick();

        // Full with backpressure
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rvfi[0] = mk(1, 0, 64'h100 + 64'(i * 16));
            rvfi[1] = mk(1, 0, 64'h108 + 64'(i * 16));
            tick();
        end
        idle_in();
        chk("full lvl", 64'(dut_level), 64'd8);
        chk("full ovf", 64'(dut_ovf), 64'd1);
        chk("full drop", 64'(dut_drop), 64'd2);
        chk("full head", dut_rvfi.pc, 64'h100);

        // Pop and push at full
        ready   = 1'b1;
        rvfi[0] = mk(1, 0, 64'h200);
        rvfi[1] = mk(1, 0, 64'h208);
        tick();
        idle_in();
        chk("popfull lvl", 64'(dut_level), 64'd8);
        chk("popfull drop", 64'(dut_drop), 64'd3);
        chk("popfull head", dut_rvfi.pc, 64'h108);

        // Flush
        repeat (3) tick();
        chk("preflush lvl", 64'(dut_level), 64'd5);
        flush   = 1'b1;
        rvfi[0] = mk(1, 0, 64'hD000);
        tick();
        idle_in();
        ready = 1'b0;
        chk("flush lvl", 64'(dut_level), 64'd1);
        chk("flush head", dut_rvfi.pc, 64'hD000);
        chk("flush drop", 64'(dut_drop), 64'd3);
        chk("flush ovf", 64'(dut_ovf), 64'd1);

`ifdef RVFI_SEQ_TOHOST_EN
        tohost  = 64'h8000_1000;
        rvfi[1] = mk(1, 0, 64'hE000);
        rvfi[1].mem_addr  = 64'h8000_1000;
        rvfi[1].mem_wmask = 8'hFF;
        rvfi[1].mem_wdata = 64'd1;
        tick();
        chk("tohost valid", 64'(dut_exit_v), 64'd1);
        chk("tohost code", dut_exit_c, 64'd1);
        rvfi[1].mem_wdata = 64'd3;
        tick();
        idle_in();
        chk("tohost keep", dut_exit_c, 64'd1);
`endif

        // Reset mid-stream
        while (mq.size() < 4) begin
            rvfi[0] = mk(1, 0, 64'hF000 + 64'(mq.size()));
            tick();
        end
        idle_in();
        chk("prerst lvl", 64'(dut_level), 64'd4);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst valid", 64'(dut_valid), 64'd0);
        chk("arst level", 64'(dut_level), 64'd0);
        chk("arst drop", 64'(dut_drop), 64'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NR; k++) begin
                rvfi[k] = mk($urandom_range(0, 9) < 5, $urandom_range(0, 9) == 0,
                             {$urandom(), $urandom()});
`ifdef RVFI_SEQ_TOHOST_EN
                if ($urandom_range(0, 49) == 0) begin
                    rvfi[k].mem_addr  = 64'h8000_1000;
                    rvfi[k].mem_wmask = 8'($urandom_range(0, 3));
                end
`endif
            end
            ready = ($urandom_range(0, 3) != 0) ^ (c[9] & c[8]);
            flush = ($urandom_range(0, 63) == 0);
`ifdef RVFI_SEQ_TOHOST_EN
            tohost = ($urandom_range(0, 7) == 0) ? 64'h0 : 64'h8000_1000;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                rst_n = 1'b1;
            end
`endif
            tick();
        end
        idle_in();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
